// File: rtl/branch_recover_pkg.sv
// Shared types and constants for the branch-recovery controller.
package branch_recover_pkg;

  // Width of PC / instruction addresses throughout the core.
  localparam int BR_ADDR_W = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PCWR  = 2'd2,
    ST_DRAIN = 2'd3
  } br_state_e;

  typedef enum logic {
    LVL_ANALYSIS = 1'b0,
    LVL_EXEC     = 1'b1
  } br_level_e;

endpackage

// File: rtl/branch_recover_stat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module branch_recover_stat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_recover_ctrl.sv
// Sequences a branch misprediction recovery: flush pulses, PC write, drain.
// Optional statistics counters are enabled with BRANCH_RECOVER_STATS_EN.
module branch_recover_ctrl
  import branch_recover_pkg::*;
#(
  parameter int ADDR_W       = BR_ADDR_W,
  parameter int DRAIN_CYCLES = 2,
  parameter int STAT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isRecoverPC,
  input  logic [ADDR_W-1:0] recoverAddress,
  input  logic              askClean_FetchMod,
  input  logic              askClean_InstParsingMod,
  input  logic              askInterHandle,
  input  logic              askRestartHandle,
  output logic              clean_fetch_o,
  output logic              clean_parse_o,
  output logic              hold_fetch_o,
  output logic              pc_wr_valid_o,
  output logic [ADDR_W-1:0] pc_wr_addr_o,
  input  logic              pc_wr_ready_i,
  output logic              busy_o
`ifdef BRANCH_RECOVER_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_exec_cnt_o,
  output logic [STAT_W-1:0] stat_anal_cnt_o
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
      (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  br_state_e         state_q, state_d;
  br_level_e         level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic abort, capture, override;

  // Fetch-clean is implied by every recovery, so the request line carries no extra information.
  logic unused_fetch_req;
  assign unused_fetch_req = askClean_FetchMod;

  assign abort    = askInterHandle | askRestartHandle;
  assign capture  = (state_q == ST_IDLE) & isRecoverPC & ~abort;
  assign override = (state_q != ST_IDLE) & isRecoverPC & askClean_InstParsingMod & ~abort;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (capture || override) begin
      state_d = ST_FLUSH;
      addr_d  = recoverAddress;
      level_d = askClean_InstParsingMod ? LVL_EXEC : LVL_ANALYSIS;
    end else begin
      case (state_q)
        ST_FLUSH: state_d = ST_PCWR;
        ST_PCWR: begin
          if (pc_wr_ready_i) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= LVL_ANALYSIS;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_fetch_o = (state_q == ST_FLUSH);
  assign clean_parse_o = (state_q == ST_FLUSH) && (level_q == LVL_EXEC);
  assign pc_wr_valid_o = (state_q == ST_PCWR);
  assign pc_wr_addr_o  = addr_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign hold_fetch_o  = busy_o;

`ifdef BRANCH_RECOVER_STATS_EN
  logic exec_inc, anal_inc;
  assign exec_inc = (capture | override) & askClean_InstParsingMod;
  assign anal_inc = capture & ~askClean_InstParsingMod;

  branch_recover_stat_cnt #(.W(STAT_W)) u_exec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (stat_clr_i),
    .inc_i (exec_inc),
    .cnt_o (stat_exec_cnt_o)
  );

  branch_recover_stat_cnt #(.W(STAT_W)) u_anal_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (stat_clr_i),
    .inc_i (anal_inc),
    .cnt_o (stat_anal_cnt_o)
  );
`else
  localparam int UNUSED_STAT_W = STAT_W;
`endif

endmodule

// File: tb/tb_branch_recover_ctrl.sv
// Directed bench for branch_recover_ctrl (ADDR_W=40, DRAIN_CYCLES=2).
module tb_branch_recover_ctrl;

  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          isRecoverPC;
  logic [AW-1:0] recoverAddress;
  logic          askClean_FetchMod;
  logic          askClean_InstParsingMod;
  logic          askInterHandle;
  logic          askRestartHandle;
  logic          clean_fetch_o;
  logic          clean_parse_o;
  logic          hold_fetch_o;
  logic          pc_wr_valid_o;
  logic [AW-1:0] pc_wr_addr_o;
  logic          pc_wr_ready_i;
  logic          busy_o;
`ifdef BRANCH_RECOVER_STATS_EN
  logic          stat_clr_i;
  logic [31:0]   stat_exec_cnt_o;
  logic [31:0]   stat_anal_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_recover_ctrl #(.ADDR_W(AW), .DRAIN_CYCLES(2), .STAT_W(32)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .isRecoverPC             (isRecoverPC),
    .recoverAddress          (recoverAddress),
    .askClean_FetchMod       (askClean_FetchMod),
    .askClean_InstParsingMod (askClean_InstParsingMod),
    .askInterHandle          (askInterHandle),
    .askRestartHandle        (askRestartHandle),
    .clean_fetch_o           (clean_fetch_o),
    .clean_parse_o           (clean_parse_o),
    .hold_fetch_o            (hold_fetch_o),
    .pc_wr_valid_o           (pc_wr_valid_o),
    .pc_wr_addr_o            (pc_wr_addr_o),
    .pc_wr_ready_i           (pc_wr_ready_i),
    .busy_o                  (busy_o)
`ifdef BRANCH_RECOVER_STATS_EN
    ,
    .stat_clr_i              (stat_clr_i),
    .stat_exec_cnt_o         (stat_exec_cnt_o),
    .stat_anal_cnt_o         (stat_anal_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One line per observed cycle; address checked only while a write is expected.
  task automatic expect_outs(input string tag, input logic cf, input logic cp,
                             input logic v, input logic busy, input logic [AW-1:0] addr);
    $display("%-14s cf=%0b cp=%0b v=%0b busy=%0b addr=%0h",
             tag, clean_fetch_o, clean_parse_o, pc_wr_valid_o, busy_o, pc_wr_addr_o);
    check({tag, ".clean_fetch"}, 64'(clean_fetch_o), 64'(cf));
    check({tag, ".clean_parse"}, 64'(clean_parse_o), 64'(cp));
    check({tag, ".valid"},       64'(pc_wr_valid_o), 64'(v));
    check({tag, ".busy"},        64'(busy_o),        64'(busy));
    check({tag, ".hold"},        64'(hold_fetch_o),  64'(busy));
    if (v) check({tag, ".addr"}, 64'(pc_wr_addr_o), 64'(addr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [AW-1:0] a, input logic exec);
    isRecoverPC             = 1'b1;
    recoverAddress          = a;
    askClean_FetchMod       = 1'b1;
    askClean_InstParsingMod = exec;
  endtask

  task automatic drop_request();
    isRecoverPC             = 1'b0;
    askClean_FetchMod       = 1'b0;
    askClean_InstParsingMod = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".idle_timeout"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drop_request();
    recoverAddress   = '0;
    askInterHandle   = 1'b0;
    askRestartHandle = 1'b0;
    pc_wr_ready_i    = 1'b0;
`ifdef BRANCH_RECOVER_STATS_EN
    stat_clr_i = 1'b0;
`endif
    tick();
    tick();
    expect_outs("reset", 0, 0, 0, 0, '0);
    check("reset.addr", 64'(pc_wr_addr_o), 64'd0);
    rst = 1'b0;
    tick();
    expect_outs("idle", 0, 0, 0, 0, '0);

    // Clean request without isRecoverPC is ignored
    askClean_InstParsingMod = 1'b1;
    tick();
    askClean_InstParsingMod = 1'b0;
    expect_outs("lone_clean", 0, 0, 0, 0, '0);

    // Analysis-level recovery, ready tied high
    pc_wr_ready_i = 1'b1;
    request(40'h00_0000_1000, 1'b0);
    tick();
    drop_request();
    expect_outs("anl.N+1", 1, 0, 0, 1, '0);
    tick(); expect_outs("anl.N+2", 0, 0, 1, 1, 40'h1000);
    tick(); expect_outs("anl.N+3", 0, 0, 0, 1, '0);
    tick(); expect_outs("anl.N+4", 0, 0, 0, 1, '0);
    tick(); expect_outs("anl.N+5", 0, 0, 0, 0, '0);

    // Execute-level recovery, write-back stalls 3 cycles
    pc_wr_ready_i = 1'b0;
    request(40'hAB_CDEF_0000, 1'b1);
    tick();
    drop_request();
    expect_outs("exe.flush", 1, 1, 0, 1, '0);
    tick(); expect_outs("exe.pcwr1", 0, 0, 1, 1, 40'hAB_CDEF_0000);
    tick(); expect_outs("exe.pcwr2", 0, 0, 1, 1, 40'hAB_CDEF_0000);
    tick(); expect_outs("exe.pcwr3", 0, 0, 1, 1, 40'hAB_CDEF_0000);
    tick(); pc_wr_ready_i = 1'b1;
    expect_outs("exe.pcwr4", 0, 0, 1, 1, 40'hAB_CDEF_0000);
    tick(); expect_outs("exe.drain1", 0, 0, 0, 1, '0);
    tick(); expect_outs("exe.drain2", 0, 0, 0, 1, '0);
    tick(); expect_outs("exe.idle", 0, 0, 0, 0, '0);

    // Override: stalled analysis write replaced by execute request
    pc_wr_ready_i = 1'b0;
    request(40'h2000, 1'b0);
    tick();
    drop_request();
    expect_outs("ovr.flush1", 1, 0, 0, 1, '0);
    tick(); expect_outs("ovr.pcwr_a", 0, 0, 1, 1, 40'h2000);
    tick(); expect_outs("ovr.pcwr_b", 0, 0, 1, 1, 40'h2000);
    request(40'h3000, 1'b1);
    tick();
    drop_request();
    pc_wr_ready_i = 1'b1;
    expect_outs("ovr.flush2", 1, 1, 0, 1, '0);
    tick(); expect_outs("ovr.pcwr_c", 0, 0, 1, 1, 40'h3000);
    tick(); tick(); tick();
    expect_outs("ovr.idle", 0, 0, 0, 0, '0);

    // Stale analysis request during DRAIN, then back-to-back at the exit cycle
    request(40'h4000, 1'b0);
    tick();
    drop_request();
    tick(); expect_outs("stl.pcwr", 0, 0, 1, 1, 40'h4000);
    tick(); request(40'h5000, 1'b0);
    expect_outs("stl.drain1", 0, 0, 0, 1, '0);
    tick(); request(40'h6000, 1'b0);
    expect_outs("stl.drain2", 0, 0, 0, 1, '0);
    tick(); expect_outs("b2b.idle", 0, 0, 0, 0, '0);
    tick(); drop_request();
    expect_outs("b2b.flush", 1, 0, 0, 1, '0);
    tick(); expect_outs("b2b.pcwr", 0, 0, 1, 1, 40'h6000);
    tick(); tick(); tick();
    expect_outs("b2b.done", 0, 0, 0, 0, '0);

    // Abort in PCWR with a same-cycle request
    pc_wr_ready_i = 1'b0;
    request(40'h7000, 1'b0);
    tick();
    drop_request();
    tick(); expect_outs("abt.pcwr", 0, 0, 1, 1, 40'h7000);
    askInterHandle = 1'b1;
    request(40'h8000, 1'b1);
    tick();
    askInterHandle = 1'b0;
    drop_request();
    expect_outs("abt.idle", 0, 0, 0, 0, '0);
    tick(); expect_outs("abt.dropped", 0, 0, 0, 0, '0);

    // Restart abort in FLUSH
    request(40'h9000, 1'b1);
    tick();
    drop_request();
    expect_outs("rsa.flush", 1, 1, 0, 1, '0);
    askRestartHandle = 1'b1;
    tick();
    askRestartHandle = 1'b0;
    expect_outs("rsa.idle", 0, 0, 0, 0, '0);

    // Reset mid-recovery
    request(40'hA000, 1'b1);
    tick();
    drop_request();
    tick(); expect_outs("rst.pcwr", 0, 0, 1, 1, 40'hA000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_outs("rst.idle", 0, 0, 0, 0, '0);
    tick(); expect_outs("rst.quiet", 0, 0, 0, 0, '0);

`ifdef BRANCH_RECOVER_STATS_EN
    pc_wr_ready_i = 1'b1;
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      request(40'h100 + 40'(i), (i != 1));
      tick();
      drop_request();
      wait_idle("stat.run");
    end
    $display("stats          exec=%0d anal=%0d", stat_exec_cnt_o, stat_anal_cnt_o);
    check("stat.exec", 64'(stat_exec_cnt_o), 64'd2);
    check("stat.anal", 64'(stat_anal_cnt_o), 64'd1);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    check("stat.exec_clr", 64'(stat_exec_cnt_o), 64'd0);
    check("stat.anal_clr", 64'(stat_anal_cnt_o), 64'd0);
`else
    wait_idle("final");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
